// File: rtl/rf_write_arbiter_pkg.sv
// rtl/rf_write_arbiter_pkg.sv - shared constants and state encoding for the register-file write arbiter
//
// Contents:
//   DATA_WIDTH        register-file data width
//   ADDRESS_WIDTH     register-file address width
//   RF_WARB_MAX_WAIT  default number of refused p1 cycles before p1 is forced (1..15)
//   warb_state_e      arbiter state: NORMAL (p0 priority) / FORCE_P1 (p1 priority)
package rf_write_arbiter_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int ADDRESS_WIDTH    = 5;
    localparam int RF_WARB_MAX_WAIT = 4;

    typedef enum logic {
        NORMAL   = 1'b0,
        FORCE_P1 = 1'b1
    } warb_state_e;

endpackage

// File: rtl/rf_warb_starve_ctr.sv
// rtl/rf_warb_starve_ctr.sv - p1 anti-starvation counter and NORMAL/FORCE_P1 state
//
// Ports:
//   clk       in   system clock, rising edge
//   res       in   synchronous reset, active-high
//   p1_valid  in   p1 has a write pending
//   p1_grant  in   p1 write accepted this cycle (p1_valid && p1_ready)
//   force_p1  out  state is FORCE_P1: p1 owns priority this cycle
module rf_warb_starve_ctr
    import rf_write_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = RF_WARB_MAX_WAIT
) (
    input  logic clk,
    input  logic res,
    input  logic p1_valid,
    input  logic p1_grant,
    output logic force_p1
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    warb_state_e state, state_next;
    logic [3:0]  wait_cnt, wait_cnt_next;
    logic        p1_refused;

    // A refusal is any cycle where p1 asks and does not win.
    assign p1_refused = p1_valid && !p1_grant;
    assign force_p1   = (state == FORCE_P1);

    always_ff @(posedge clk) begin
        if (res) begin
            state    <= NORMAL;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        wait_cnt_next = wait_cnt;
        state_next    = state;

        if (!p1_refused) begin
            wait_cnt_next = 4'd0;
        end else if (wait_cnt < MAX_CNT) begin
            wait_cnt_next = wait_cnt + 4'd1;
        end

        case (state)
            NORMAL: begin
                if (p1_refused && (wait_cnt_next == MAX_CNT)) begin
                    state_next = FORCE_P1;
                end
            end
            FORCE_P1: begin
                // Leave as soon as p1 is served or stops asking.
                if (!p1_valid || p1_grant) begin
                    state_next = NORMAL;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - two-source arbiter for the single register-file write port
//
// Optional feature macro: RF_WRITE_ARBITER_BYPASS_EN (read-port forwarding of the in-flight write)
//
// Ports:
//   clk, res                 clock, synchronous active-high reset
//   p0_valid/ready/addr/data execute writeback source (default priority)
//   p1_valid/ready/addr/data late writeback source (loads, multicycle results)
//   rf_we, rf_a3, rf_wd      registered register-file write port
//   p1_forced                high while p1 holds forced priority
//   rd_a1, rd_a2             (bypass only) read addresses
//   rd1_in, rd2_in           (bypass only) register-file read data
//   rd1_fwd, rd2_fwd         (bypass only) read data with in-flight write forwarded
module rf_write_arbiter #(
    parameter int DATA_WIDTH = rf_write_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_write_arbiter_pkg::ADDRESS_WIDTH,
    parameter int MAX_WAIT   = rf_write_arbiter_pkg::RF_WARB_MAX_WAIT
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  p0_valid,
    output logic                  p0_ready,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_data,
    input  logic                  p1_valid,
    output logic                  p1_ready,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_a3,
    output logic [DATA_WIDTH-1:0] rf_wd,
`ifdef RF_WRITE_ARBITER_BYPASS_EN
    input  logic [ADDR_WIDTH-1:0] rd_a1,
    input  logic [ADDR_WIDTH-1:0] rd_a2,
    input  logic [DATA_WIDTH-1:0] rd1_in,
    input  logic [DATA_WIDTH-1:0] rd2_in,
    output logic [DATA_WIDTH-1:0] rd1_fwd,
    output logic [DATA_WIDTH-1:0] rd2_fwd,
`endif
    output logic                  p1_forced
);

    logic force_p1;
    logic p0_grant;
    logic p1_grant;

    rf_warb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk      (clk),
        .res      (res),
        .p1_valid (p1_valid),
        .p1_grant (p1_grant),
        .force_p1 (force_p1)
    );

    assign p1_forced = force_p1;

    // Readies depend only on valids and state; both are held low in reset so
    // nothing is consumed that the output stage would then discard.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (!res) begin
            if (force_p1) begin
                p1_ready = p1_valid;
                p0_ready = p0_valid && !p1_valid;
            end else begin
                p0_ready = p0_valid;
                p1_ready = p1_valid && !p0_valid;
            end
        end
    end

    assign p0_grant = p0_valid && p0_ready;
    assign p1_grant = p1_valid && p1_ready;

    // Address/data hold between grants; x0 writes are consumed but never enabled.
    always_ff @(posedge clk) begin
        if (res) begin
            rf_we <= 1'b0;
            rf_a3 <= '0;
            rf_wd <= '0;
        end else if (p0_grant) begin
            rf_we <= (p0_addr != '0);
            rf_a3 <= p0_addr;
            rf_wd <= p0_data;
        end else if (p1_grant) begin
            rf_we <= (p1_addr != '0);
            rf_a3 <= p1_addr;
            rf_wd <= p1_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef RF_WRITE_ARBITER_BYPASS_EN
    // The write on rf_* lands at the next edge; reads this cycle see it early.
    assign rd1_fwd = (rf_we && (rf_a3 == rd_a1) && (rd_a1 != '0)) ? rf_wd : rd1_in;
    assign rd2_fwd = (rf_we && (rf_a3 == rd_a2) && (rd_a2 != '0)) ? rf_wd : rd2_in;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - randomized self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          res;
    logic          p0_valid, p0_ready, p1_valid, p1_ready;
    logic [AW-1:0] p0_addr, p1_addr, rf_a3;
    logic [DW-1:0] p0_data, p1_data, rf_wd;
    logic          rf_we, p1_forced;
`ifdef RF_WRITE_ARBITER_BYPASS_EN
    logic [AW-1:0] rd_a1 = '0, rd_a2 = '0;
    logic [DW-1:0] rd1_in = '0, rd2_in = '0, rd1_fwd, rd2_fwd;
`endif

    always #5 clk = ~clk;

    rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .res(res),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
`ifdef RF_WRITE_ARBITER_BYPASS_EN
        .rd_a1(rd_a1), .rd_a2(rd_a2), .rd1_in(rd1_in), .rd2_in(rd2_in),
        .rd1_fwd(rd1_fwd), .rd2_fwd(rd2_fwd),
`endif
        .p1_forced(p1_forced)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source-side requests: each source holds its write until it is accepted.
    bit            v0, v1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;

    // Reference model: p1 wins ties once it has been turned away MW cycles in a row.
    int            m_refused;
    logic          m_we;
    logic [AW-1:0] m_a3;
    logic [DW-1:0] m_wd;

    bit g0, g1, obs_p1r;

    task automatic step(input bit r);
        bit e0r, e1r, p1_prio;
        res = r; p0_valid = v0; p0_addr = a0; p0_data = d0;
        p1_valid = v1; p1_addr = a1; p1_data = d1;
        @(negedge clk);
        p1_prio = (m_refused >= MW);
        e0r = 1'b0; e1r = 1'b0;
        if (!r) begin
            if (v0 && v1) begin
                e0r = !p1_prio;
                e1r = p1_prio;
            end else begin
                e0r = v0;
                e1r = v1;
            end
        end
        check("p0_ready", p0_ready, e0r);
        check("p1_ready", p1_ready, e1r);
        check("p1_forced", p1_forced, p1_prio);
        check("rf_we", rf_we, m_we);
        check("rf_a3", rf_a3, m_a3);
        check("rf_wd", rf_wd, m_wd);
        obs_p1r = p1_ready;
        g0 = v0 && e0r;
        g1 = v1 && e1r;
        @(posedge clk);
        if (r) begin
            m_refused = 0; m_we = 0; m_a3 = '0; m_wd = '0;
        end else begin
            if (!v1 || g1) m_refused = 0;
            else if (m_refused < MW) m_refused++;
            if (g0)      begin m_we = (a0 != 0); m_a3 = a0; m_wd = d0; end
            else if (g1) begin m_we = (a1 != 0); m_a3 = a1; m_wd = d1; end
            else         m_we = 0;
        end
        #1;
    endtask

    initial begin
        m_refused = 0; m_we = 0; m_a3 = '0; m_wd = '0;
        v0 = 1; v1 = 1; a0 = 5'd3; a1 = 5'd4; d0 = 32'h1; d1 = 32'h2;

        // Reset with both sources asking: nothing is accepted.
        step(1); step(1);
        v0 = 0; v1 = 0;
        step(0); step(0);
        check("idle_we", rf_we, 1'b0);
        check("idle_a3", rf_a3, 5'd0);

        // Single p0 write, one-cycle latency to the write port.
        v0 = 1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        step(0);
        check("p0_single_grant", g0, 1'b1);
        check("p0_single_we", rf_we, 1'b1);
        check("p0_single_a3", rf_a3, 5'd5);
        check("p0_single_wd", rf_wd, 32'hDEADBEEF);
        v0 = 0;
        step(0);

        // Sustained contention: p1 wins every fifth cycle.
        v0 = 1; v1 = 1; a0 = 5'd10; a1 = 5'd11;
        for (int i = 0; i < 10; i++) begin
            step(0);
            check("contend_p1_slot", obs_p1r, (i % 5) == 4);
        end
        v0 = 0; v1 = 0;
        step(0);

        // x0 write on p1 is consumed without a write enable.
        v1 = 1; a1 = 5'd0; d1 = 32'h1234;
        step(0);
        check("x0_ready", obs_p1r, 1'b1);
        check("x0_we", rf_we, 1'b0);
        v1 = 0;
        step(0);

        // Reset right after a grant, with the starvation count part-way up.
        v0 = 1; v1 = 1; a0 = 5'd9; a1 = 5'd12; d0 = 32'h99;
        step(0); step(0);
        step(1);
        check("reset_drop_we", rf_we, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(0);
            check("post_reset_slot", obs_p1r, i == 4);
        end
        v0 = 0; v1 = 0;
        step(0);

`ifdef RF_WRITE_ARBITER_BYPASS_EN
        v0 = 1; a0 = 5'd7; d0 = 32'hA5A5A5A5;
        step(0);
        v0 = 0;
        rd_a1 = 5'd7; rd1_in = 32'h0BADF00D; #1;
        check("fwd_hit", rd1_fwd, 32'hA5A5A5A5);
        rd_a1 = 5'd0; #1;
        check("fwd_x0", rd1_fwd, 32'h0BADF00D);
        rd_a2 = 5'd8; rd2_in = 32'h5555; #1;
        check("fwd_miss", rd2_fwd, 32'h5555);
        step(0);
`endif

        // Randomized traffic at several densities with occasional resets.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 600; c++) begin
                if (!v0 && ($urandom_range(3) <= ph)) begin
                    v0 = 1; a0 = ($urandom_range(3) == 0) ? 5'd0 : AW'($urandom);
                    d0 = $urandom;
                end
                if (!v1 && ($urandom_range(3) <= ph)) begin
                    v1 = 1; a1 = ($urandom_range(3) == 0) ? 5'd0 : AW'($urandom);
                    d1 = $urandom;
                end
`ifdef RF_WRITE_ARBITER_BYPASS_EN
                rd_a1 = AW'($urandom); rd_a2 = m_a3; rd1_in = $urandom; rd2_in = $urandom; #1;
                check("rnd_fwd1", rd1_fwd, (m_we && m_a3 == rd_a1 && rd_a1 != 0) ? m_wd : rd1_in);
                check("rnd_fwd2", rd2_fwd, (m_we && m_a3 == rd_a2 && rd_a2 != 0) ? m_wd : rd2_in);
`endif
                step($urandom_range(99) == 0);
                if (g0) v0 = 0;
                if (g1) v1 = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (we/A3/WD) between two writeback sources:
  - p0: execute/ALU writeback, the default-priority source.
  - p1: late writeback, i.e. load data and multicycle results.
- Fixed priority to p0, with an anti-starvation counter that forces a p1 grant.
- Granted writes are registered, then drive the register file's write port one cycle later.

Parameters:
- DATA_WIDTH, 32, width of write data; equals the shared DATA_WIDTH constant.
- ADDR_WIDTH, 5, register address width; equals the shared ADDRESS_WIDTH constant.
- MAX_WAIT, 4, number of consecutive cycles p1 may be refused before it is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  synchronous reset, active-high.
- p0_valid  in  1  p0 has a write pending.
- p0_ready  out  1  p0 write accepted this cycle.
- p0_addr  in  ADDR_WIDTH  p0 destination register.
- p0_data  in  DATA_WIDTH  p0 write data.
- p1_valid  in  1  p1 has a write pending.
- p1_ready  out  1  p1 write accepted this cycle.
- p1_addr  in  ADDR_WIDTH  p1 destination register.
- p1_data  in  DATA_WIDTH  p1 write data.
- rf_we  out  1  to the register file's write enable.
- rf_a3  out  ADDR_WIDTH  to the register file's write address.
- rf_wd  out  DATA_WIDTH  to the register file's write data.
- p1_forced  out  1  high while the state is FORCE_P1 (debug/perf).

Behaviour:
- Single clock clk. Reset res is synchronous and active-high; all state is updated on the rising edge of clk.
- Reset values: rf_we=0, rf_a3=0, rf_wd=0, wait_cnt=0, state=NORMAL, p1_forced=0. While res=1, p0_ready=p1_ready=0.
- Handshake: a transfer occurs when valid&&ready. Ready is combinational from the valids and state, never from the data. Once valid is raised, the source holds valid, addr and data stable until ready.
- At most one grant per cycle.
- State NORMAL:
  - p0_ready = p0_valid.
  - p1_ready = p1_valid && !p0_valid.
- State FORCE_P1:
  - p1_ready = p1_valid.
  - p0_ready = p0_valid && !p1_valid.
- wait_cnt (4 bits):
  - Cleared on any p1 grant, or when p1_valid=0.
  - Otherwise, when p1_valid && !p1_ready, increments and saturates at MAX_WAIT.
- Transitions:
  - NORMAL -> FORCE_P1 at the edge where the incremented wait_cnt reaches MAX_WAIT.
  - FORCE_P1 -> NORMAL at the edge of the p1 grant, or if p1_valid drops.
- Output stage, at each edge:
  - rf_we <= grant && (granted addr != 0).
  - rf_a3 <= granted addr; rf_wd <= granted data.
  - Both are updated only when a grant occurs; otherwise they hold their values with rf_we=0.
- Latency: grant at edge N drives rf_we/rf_a3/rf_wd during cycle N+1. The register file commits the write at edge N+1.
- x0 writes: still handshaken (ready=1 and consumed) but never produce rf_we.
- Same-register writes from both ports in the same cycle: only the granted one proceeds. Write ordering across ports is the issuing logic's responsibility.
- Reset mid-operation: a pending grant is dropped, with no rf_we the next cycle. Sources must re-present their writes after reset.
- MAX_WAIT=1: p1 is forced after a single refused cycle, so sustained traffic alternates strictly between p0 and p1.

Optional Feature:
- Macro: RF_WRITE_ARBITER_BYPASS_EN.
- Defined: adds the following ports:
  - rd_a1, rd_a2: ADDR_WIDTH inputs.
  - rd1_in, rd2_in: DATA_WIDTH inputs, from the register file's RD1/RD2.
  - rd1_fwd, rd2_fwd: DATA_WIDTH outputs.
- Forwarding rule: rdN_fwd = rf_wd when rf_we && rf_a3==rd_aN && rd_aN!=0, else rdN_in. This is purely combinational and covers the write landing at the next edge.
- Not defined: these ports and the forwarding logic do not exist.

Decomposition:
- Shared constants header: DATA_WIDTH, ADDRESS_WIDTH, and the state encodings for the arbiter (NORMAL=1'b0, FORCE_P1=1'b1). Add a RF_WARB_MAX_WAIT default there.
- One natural sub-module: rf_warb_starve_ctr, holding wait_cnt and the NORMAL/FORCE_P1 state. Outputs: force flag. Inputs: p1_valid, p1_grant.

Test Plan:
- Reset: res=1 with both valids high for 2 cycles -> both readies 0; after release, rf_we=0 and rf_a3=0 until the first grant.
- Single p0 write, addr=5, data=0xDEADBEEF -> p0_ready same cycle; next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF.
- Both valid continuously, MAX_WAIT=4 -> p0 granted 4 cycles, p1_forced=1, p1 granted on the 5th, then p0 resumes; pattern repeats every 5 cycles.
- x0 write on p1, addr=0, data=0x1234 with p0 idle -> p1_ready=1; rf_we stays 0.
- res asserted the cycle after a p0 grant -> rf_we=0 in the following cycle; state=NORMAL and wait_cnt=0.
- With RF_WRITE_ARBITER_BYPASS_EN: rf_we=1, rf_a3=7, rf_wd=0xA5A5A5A5 -> rd_a1=7 gives rd1_fwd=0xA5A5A5A5; rd_a1=0 gives rd1_fwd=rd1_in.
